// File: rtl/fwd_stall_ctrl_pkg.sv
// Shared types for the forwarding/stall controller: operand-select encodings
// and the per-stage scoreboard entry.
package fwd_stall_ctrl_pkg;

    localparam int REG_AW = 3;

    typedef enum logic [1:0] {
        SEL_RF    = 2'b00,
        SEL_EXMEM = 2'b01,
        SEL_MEMWB = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              wr;
        logic              load;
    } sb_entry_t;

    typedef struct packed {
        sb_entry_t ex;
        sb_entry_t mem;
        sb_entry_t wb;
    } sb_state_t;

endpackage

// File: rtl/fwd_stall_if.sv
// ID-stage request and hazard-control response bundle. The ID side drives the
// instruction description; the controller answers with stall/forward controls.
// Handshake: no valid/ready; id_valid qualifies the ID fields every cycle, and
// stall is the only back-pressure (ID must hold its fields while stall is high).
interface fwd_stall_if #(
    parameter int REG_AW = 3,
    parameter int CNT_W  = 16
);
    import fwd_stall_ctrl_pkg::*;

    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic [REG_AW-1:0] id_rd;
    logic              id_wr_en;
    logic              id_is_load;
    logic              ex_flush;

    logic              stall;
    logic [1:0]        fwd_a_sel;
    logic [1:0]        fwd_b_sel;
    logic              idex_bubble;
    logic [CNT_W-1:0]  stall_cnt;
    sb_state_t         sb_dbg;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_wr_en, id_is_load, ex_flush,
        input  stall, fwd_a_sel, fwd_b_sel, idex_bubble, stall_cnt, sb_dbg
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_wr_en, id_is_load, ex_flush,
        output stall, fwd_a_sel, fwd_b_sel, idex_bubble, stall_cnt, sb_dbg
    );

endinterface

// File: rtl/fwd_stall_ctrl_match.sv
// Compares one source register against one scoreboard entry; r0 never matches
// because it is hardwired to zero.
module fwd_match
    import fwd_stall_ctrl_pkg::*;
(
    input  logic [REG_AW-1:0] src_i,
    input  logic              used_i,
    input  sb_entry_t         entry_i,
    output logic              hit_o
);

    assign hit_o = used_i && (src_i != '0) && entry_i.valid && entry_i.wr
                   && (entry_i.rd == src_i);

endmodule

// File: rtl/fwd_stall_ctrl.sv
// Load-use stall detection and EX operand forwarding control for a 5-stage
// pipeline, driven by a three-entry EX/MEM/WB scoreboard.
module fwd_stall_ctrl #(
    parameter int REG_AW = fwd_stall_ctrl_pkg::REG_AW,
    parameter int CNT_W  = 16
) (
    input logic      clk,
    input logic      rst,
    fwd_stall_if.slave bus
);
    import fwd_stall_ctrl_pkg::*;

    sb_entry_t        ex_q, mem_q, wb_q, ex_d;
    fwd_sel_e         a_sel_q, b_sel_q, a_sel_d, b_sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [REG_AW-1:0] rs1, rs2, rd;
    logic a_ex, a_mem, b_ex, b_mem;
    logic stall, bubble, issue;

    assign rs1 = bus.id_rs1;
    assign rs2 = bus.id_rs2;
    assign rd  = bus.id_rd;

    fwd_match u_a_ex  (.src_i(rs1), .used_i(bus.id_rs1_used), .entry_i(ex_q),  .hit_o(a_ex));
    fwd_match u_a_mem (.src_i(rs1), .used_i(bus.id_rs1_used), .entry_i(mem_q), .hit_o(a_mem));
    fwd_match u_b_ex  (.src_i(rs2), .used_i(bus.id_rs2_used), .entry_i(ex_q),  .hit_o(b_ex));
    fwd_match u_b_mem (.src_i(rs2), .used_i(bus.id_rs2_used), .entry_i(mem_q), .hit_o(b_mem));

    always_comb begin
        stall = 1'b0;
        if (!rst && bus.id_valid && !bus.ex_flush && ex_q.load && (a_ex || b_ex))
            stall = 1'b1;
        bubble = stall || (!rst && bus.ex_flush);
        issue  = bus.id_valid && !stall && !bus.ex_flush;

        ex_d = '0;
        if (issue)
            ex_d = '{valid: 1'b1, rd: rd, wr: bus.id_wr_en, load: bus.id_is_load};

        // An issuing instruction never sees an EX load match (that case stalls),
        // so an EX hit here is always forwardable from EX/MEM.
        a_sel_d = SEL_RF;
        b_sel_d = SEL_RF;
        if (issue) begin
            if (a_ex)       a_sel_d = SEL_EXMEM;
            else if (a_mem) a_sel_d = SEL_MEMWB;
            if (b_ex)       b_sel_d = SEL_EXMEM;
            else if (b_mem) b_sel_d = SEL_MEMWB;
        end

        cnt_d = cnt_q;
        if (stall && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            a_sel_q <= SEL_RF;
            b_sel_q <= SEL_RF;
            cnt_q   <= '0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= ex_q;
            wb_q    <= mem_q;
            a_sel_q <= a_sel_d;
            b_sel_q <= b_sel_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.stall       = stall;
    assign bus.idex_bubble = bubble;
    assign bus.fwd_a_sel   = a_sel_q;
    assign bus.fwd_b_sel   = b_sel_q;
    assign bus.stall_cnt   = cnt_q;
    assign bus.sb_dbg      = '{ex: ex_q, mem: mem_q, wb: wb_q};

endmodule

// File: tb/tb_fwd_stall_ctrl.sv
// Directed and random checks of the forwarding/stall controller against a
// model that reasons about instruction age of the youngest prior writer.
module tb_fwd_stall_ctrl;

    localparam int AW      = 3;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    typedef struct {
        logic       valid;
        logic [2:0] rd;
        logic       wr;
        logic       ld;
    } instr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fwd_stall_if #(.REG_AW(AW), .CNT_W(CW)) bus ();

    fwd_stall_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    instr_t     hist[$];
    logic [1:0] exp_a = 2'b00;
    logic [1:0] exp_b = 2'b00;
    int         exp_cnt = 0;
    logic       last_stall = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Age 0 = instruction one ahead (now in EX), age 1 = two ahead (in MEM).
    function automatic int youngest_writer(input int src, input int used);
        if (used == 0 || src == 0) return -1;
        for (int age = 0; age < 2 && age < hist.size(); age++)
            if (hist[age].valid && hist[age].wr && (int'(hist[age].rd) == src))
                return age;
        return -1;
    endfunction

    function automatic logic [1:0] sel_for_age(input int age);
        if (age == 0) return 2'b01;
        if (age == 1) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_clear();
        instr_t inv;
        inv = '{valid: 1'b0, rd: 3'd0, wr: 1'b0, ld: 1'b0};
        hist.delete();
        hist.push_back(inv);
        hist.push_back(inv);
        exp_a   = 2'b00;
        exp_b   = 2'b00;
        exp_cnt = 0;
    endtask

    task automatic cyc(input int v, input int rs1, input int u1, input int rs2, input int u2,
                       input int rd, input int we, input int ld, input int fl);
        int     age_a, age_b;
        logic   exp_stall, exp_bub, issued;
        instr_t ins;
        bus.id_valid    = 1'(v);
        bus.id_rs1      = 3'(rs1);
        bus.id_rs1_used = 1'(u1);
        bus.id_rs2      = 3'(rs2);
        bus.id_rs2_used = 1'(u2);
        bus.id_rd       = 3'(rd);
        bus.id_wr_en    = 1'(we);
        bus.id_is_load  = 1'(ld);
        bus.ex_flush    = 1'(fl);
        #1;
        age_a = youngest_writer(rs1, u1);
        age_b = youngest_writer(rs2, u2);
        exp_stall = !rst && (v != 0) && (fl == 0) && hist[0].ld && (age_a == 0 || age_b == 0);
        exp_bub   = !rst && (exp_stall || fl != 0);
        issued    = (v != 0) && !exp_stall && (fl == 0);
        check("stall", 32'(bus.stall), 32'(exp_stall));
        check("idex_bubble", 32'(bus.idex_bubble), 32'(exp_bub));
        last_stall = exp_stall;
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            exp_a = issued ? sel_for_age(age_a) : 2'b00;
            exp_b = issued ? sel_for_age(age_b) : 2'b00;
            if (exp_stall && exp_cnt < CNT_MAX) exp_cnt++;
            ins = '{valid: issued, rd: issued ? 3'(rd) : 3'd0,
                    wr: issued && (we != 0), ld: issued && (ld != 0)};
            hist.push_front(ins);
            void'(hist.pop_back());
        end
        #1;
        check("fwd_a_sel", 32'(bus.fwd_a_sel), 32'(exp_a));
        check("fwd_b_sel", 32'(bus.fwd_b_sel), 32'(exp_b));
        check("stall_cnt", 32'(bus.stall_cnt), 32'(exp_cnt));
        check("ex_valid", 32'(bus.sb_dbg.ex.valid), 32'(hist[0].valid));
    endtask

    task automatic nop();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic alu(input int rd, input int rs1, input int rs2);
        cyc(1, rs1, 1, rs2, 1, rd, 1, 0, 0);
    endtask

    task automatic load(input int rd, input int rs1);
        cyc(1, rs1, 1, 0, 0, rd, 1, 1, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int v, r1, u1, r2, u2, rd, we, ld, fl;
        model_clear();
        rst = 1'b1;
        @(posedge clk);
        #1;
        nop();
        alu(1, 1, 1);
        rst = 1'b0;
        check("reset_a_sel", 32'(bus.fwd_a_sel), 32'd0);
        check("reset_cnt", 32'(bus.stall_cnt), 32'd0);

        // back-to-back ALU dependency forwards from EX/MEM
        alu(1, 2, 3);
        alu(2, 1, 3);
        check("alu_alu_a", 32'(bus.fwd_a_sel), 32'b01);
        nop(); nop();

        // load-use: one stall then retry forwards from MEM/WB on both operands
        load(1, 5);
        alu(2, 1, 1);
        check("load_use_cnt", 32'(bus.stall_cnt), 32'd1);
        alu(2, 1, 1);
        check("load_use_a", 32'(bus.fwd_a_sel), 32'b10);
        check("load_use_b", 32'(bus.fwd_b_sel), 32'b10);
        nop(); nop();

        // youngest writer wins
        alu(1, 2, 3);
        alu(1, 3, 2);
        alu(4, 1, 5);
        check("youngest_a", 32'(bus.fwd_a_sel), 32'b01);
        nop(); nop();

        // r0 never forwards
        alu(0, 2, 3);
        alu(5, 0, 0);
        check("r0_a", 32'(bus.fwd_a_sel), 32'b00);
        check("r0_b", 32'(bus.fwd_b_sel), 32'b00);
        nop(); nop();

        // flush overrides a load-use hazard
        load(1, 5);
        cyc(1, 1, 1, 3, 1, 2, 1, 0, 1);
        check("flush_ex_invalid", 32'(bus.sb_dbg.ex.valid), 32'd0);
        nop(); nop();

        // reset in the middle of a pending hazard
        load(1, 5);
        rst = 1'b1;
        alu(2, 1, 1);
        rst = 1'b0;
        alu(2, 1, 1);
        check("post_reset_a", 32'(bus.fwd_a_sel), 32'b00);
        nop(); nop();

        // random traffic; ID holds its instruction while stalled
        v = 0; r1 = 0; u1 = 0; r2 = 0; u2 = 0; rd = 0; we = 0; ld = 0;
        for (int i = 0; i < 400; i++) begin
            if (!last_stall) begin
                v  = ($urandom_range(0, 9) != 0) ? 1 : 0;
                r1 = $urandom_range(0, 3);
                u1 = $urandom_range(0, 1);
                r2 = $urandom_range(0, 3);
                u2 = $urandom_range(0, 1);
                rd = $urandom_range(0, 3);
                we = ($urandom_range(0, 4) != 0) ? 1 : 0;
                ld = $urandom_range(0, 1);
            end
            fl  = ($urandom_range(0, 9) == 0) ? 1 : 0;
            rst = ($urandom_range(0, 99) == 0);
            cyc(v, r1, u1, r2, u2, rd, we, ld, fl);
            rst = 1'b0;
        end
        nop(); nop();

        // drive the counter past its maximum
        rst = 1'b1;
        nop();
        rst = 1'b0;
        for (int i = 0; i < CNT_MAX + 4; i++) begin
            load(1, 5);
            alu(2, 1, 1);
            alu(2, 1, 1);
        end
        check("cnt_saturated", 32'(bus.stall_cnt), 32'(CNT_MAX));
        rst = 1'b1;
        nop();
        rst = 1'b0;
        check("cnt_cleared", 32'(bus.stall_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fwd_stall_ctrl.md
FWD_STALL_CTRL -- requirements
Module: fwd_stall_ctrl

Interface
REQ-001 Parameter REG_AW, default 3, register-address width; register 0 is hardwired zero.
REQ-002 Parameter CNT_W, default 16, stall-counter width.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 id_valid  in  1  ID stage holds a real instruction.
REQ-006 id_rs1, id_rs2  in  REG_AW each  source register addresses in ID.
REQ-007 id_rs1_used, id_rs2_used  in  1 each  source actually read.
REQ-008 id_rd  in  REG_AW  destination register in ID.
REQ-009 id_wr_en  in  1  ID instruction writes id_rd.
REQ-010 id_is_load  in  1  ID instruction's result exists only after MEM.
REQ-011 ex_flush  in  1  taken branch/jump resolved in EX; kills ID instruction.
REQ-012 stall  out  1  hold PC and IF/ID; inject bubble into ID/EX.
REQ-013 fwd_a_sel, fwd_b_sel  out  2 each  EX operand mux select: 00 regfile, 01 EX/MEM result, 10 MEM/WB result, 11 unused.
REQ-014 idex_bubble  out  1  ID/EX register loads a NOP this edge.
REQ-015 stall_cnt  out  CNT_W  saturating count of stall cycles since reset.

Function
REQ-016 Internal scoreboard of three entries, EX, MEM, WB; each holds valid, rd, wr, load.
REQ-017 Each edge, WB<=MEM, MEM<=EX, EX<=ID info; EX loads invalid when stall or ex_flush is high, or when id_valid is low.
REQ-018 A source matches an entry only if: source used, address nonzero, entry valid, entry wr high, entry rd equal.
REQ-019 stall is combinational: high when id_valid, ex_flush low, and either source matches the EX entry with load=1.
REQ-020 idex_bubble = stall OR ex_flush.
REQ-021 ex_flush suppresses stall in the same cycle; flush wins over stall.
REQ-022 Forward selects are computed in ID and registered, so they are valid in the cycle the instruction occupies EX (latency 1).
REQ-023 Per source: match on EX entry (non-load) -> 01; else match on MEM entry -> 10; else 00; the EX entry (younger) has priority over MEM.
REQ-024 A MEM-entry load match yields 10 (load data forwarded from MEM/WB).
REQ-025 WB-entry matches yield 00; the regfile is write-before-read.
REQ-026 When a bubble is registered into EX, the registered selects load 00.
REQ-027 Load-use hazard costs exactly one stall cycle; on the retry cycle the load is in MEM and the select is 10.
REQ-028 stall_cnt increments by 1 each cycle stall is high; it holds at all-ones and never wraps.
REQ-029 rs1 = rs2 = same register is handled independently per operand; both selects may be equal.

Reset
REQ-030 On rst high at an edge: all scoreboard entries invalid, fwd_a_sel = fwd_b_sel = 00, stall_cnt = 0.
REQ-031 While rst is high, stall and idex_bubble are driven 0.
REQ-032 Reset mid-stall discards the pending hazard; first cycle after reset issues no stall.

Structure
REQ-033 A shared package holds REG_AW, the select encodings (SEL_RF, SEL_EXMEM, SEL_MEMWB) and the scoreboard entry struct.
REQ-034 One sub-module, fwd_match, compares one source against one entry; instantiated once per source per entry (4 total).
REQ-035 Purely synchronous; no latches; only stall and idex_bubble are combinational outputs.

Verification
REQ-036 ADD r1 then ADD r2,r1,r3 back-to-back -> no stall; fwd_a_sel=01 in second instruction's EX cycle.
REQ-037 LOAD r1 then ADD r2,r1,r1 -> stall=1 for one cycle, stall_cnt 0->1; retry has fwd_a_sel=fwd_b_sel=10.
REQ-038 ADD r1, ADD r1, SUB r4,r1 -> SUB gets 01 (youngest writer), not 10.
REQ-039 Writer to r0 followed by reader of r0 -> selects 00, no stall.
REQ-040 LOAD r1, ADD r2,r1 with ex_flush=1 in the hazard cycle -> stall=0, idex_bubble=1, EX entry invalid next cycle.
REQ-041 Force 2^CNT_W+3 load-use stalls -> stall_cnt saturates at all-ones; rst then clears it to 0.
